// File: rtl/rom_fetch_pkg.sv
// rom_fetch shared types and sizes.
// ROM read front-end for the SDRAM controller.
package rom_fetch_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;
    localparam int LW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

endpackage

// File: rtl/rom_line_buf.sv
// One cache line of ROM words with per-word valid bits.
// Clear-all wins over a write in the same cycle.
import rom_fetch_pkg::*;

module rom_line_buf #(
    parameter int LW = LW_DEF
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [LW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int N = 1 << LW;

    logic [DATA_W-1:0] word [N];
    logic [N-1:0]      valid;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            valid <= '0;
            for (int i = 0; i < N; i++) begin
                word[i] <= '0;
            end
        end else begin
            if (clr) begin
                valid <= '0;
            end else if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end
            if (wr_en) begin
                word[wr_idx] <= wr_data;
            end
        end
    end

    assign rd_data  = word[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/rom_fetch.sv
// CPU ROM read front-end: level req / pulse ack to toggle handshake,
// with a critical-word-first, wrapping single-line buffer.
import rom_fetch_pkg::*;

module rom_fetch #(
    parameter int LW = LW_DEF
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_a,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              inval,
    output logic              busy,
    output logic              romrd_req,
    input  logic              romrd_ack,
    output logic [ADDR_W-1:0] romrd_a,
    input  logic [DATA_W-1:0] romrd_q
);

    localparam int N = 1 << LW;
    localparam int TAG_W = ADDR_W - LW;
    localparam logic [LW:0] LAST = (LW+1)'(N - 1);

    state_t            state, state_n;
    logic [TAG_W-1:0]  tag, tag_n;
    logic [LW-1:0]     fill_idx, fill_idx_n;
    logic [LW:0]       fill_cnt, fill_cnt_n;
    logic              crit, crit_n;
    logic              abort, abort_n;
    logic              ack_n;
    logic [DATA_W-1:0] q_n;
    logic              req_n;
    logic [ADDR_W-1:0] a_n;

    logic              buf_clr;
    logic              buf_we;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;

    logic [LW-1:0]     req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [LW-1:0]     nxt_idx;
    logic              ack_done;
    logic              take;
    logic              tag_eq;
    logic              hit;
    logic              drop;

    assign req_idx  = cpu_a[LW-1:0];
    assign req_tag  = cpu_a[ADDR_W-1:LW];
    assign nxt_idx  = fill_idx + 1'b1;
    assign ack_done = (romrd_ack == romrd_req);
    assign take     = cpu_req && !cpu_ack;
    assign tag_eq   = (req_tag == tag);
    assign hit      = take && tag_eq && buf_valid;
    // A new line is only wanted once the critical word is delivered
    assign drop     = inval || (take && !crit && !tag_eq);
    assign busy     = (romrd_req != romrd_ack);

    rom_line_buf #(
        .LW (LW)
    ) u_buf (
        .clk      (clk),
        .init_n   (init_n),
        .clr      (buf_clr),
        .wr_en    (buf_we),
        .wr_idx   (fill_idx),
        .wr_data  (romrd_q),
        .rd_idx   (req_idx),
        .rd_data  (buf_data),
        .rd_valid (buf_valid)
    );

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state     <= IDLE;
            tag       <= '0;
            fill_idx  <= '0;
            fill_cnt  <= '0;
            crit      <= 1'b0;
            abort     <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_q     <= '0;
            romrd_req <= 1'b0;
            romrd_a   <= '0;
        end else begin
            state     <= state_n;
            tag       <= tag_n;
            fill_idx  <= fill_idx_n;
            fill_cnt  <= fill_cnt_n;
            crit      <= crit_n;
            abort     <= abort_n;
            cpu_ack   <= ack_n;
            cpu_q     <= q_n;
            romrd_req <= req_n;
            romrd_a   <= a_n;
        end
    end

    always_comb begin
        state_n    = state;
        tag_n      = tag;
        fill_idx_n = fill_idx;
        fill_cnt_n = fill_cnt;
        crit_n     = crit;
        abort_n    = abort;
        ack_n      = 1'b0;
        q_n        = cpu_q;
        req_n      = romrd_req;
        a_n        = romrd_a;
        buf_clr    = 1'b0;
        buf_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (inval) begin
                    buf_clr = 1'b1;
                end
                if (take && hit && !inval) begin
                    ack_n = 1'b1;
                    q_n   = buf_data;
                end else if (take) begin
                    tag_n      = req_tag;
                    buf_clr    = 1'b1;
                    fill_idx_n = req_idx;
                    fill_cnt_n = '0;
                    crit_n     = 1'b1;
                    a_n        = cpu_a;
                    req_n      = ~romrd_req;
                    state_n    = FILL;
                end
            end
            FILL: begin
                if (drop) begin
                    buf_clr = 1'b1;
                    crit_n  = 1'b0;
                    // Nothing in flight once the ack is consumed here
                    if (ack_done) begin
                        state_n = IDLE;
                    end else begin
                        abort_n = 1'b1;
                        state_n = DRAIN;
                    end
                end else begin
                    if (ack_done) begin
                        buf_we = 1'b1;
                        if (crit) begin
                            ack_n  = 1'b1;
                            q_n    = romrd_q;
                            crit_n = 1'b0;
                        end
                        if (fill_cnt == LAST) begin
                            state_n = IDLE;
                        end else begin
                            fill_idx_n = nxt_idx;
                            fill_cnt_n = fill_cnt + 1'b1;
                            a_n        = {tag, nxt_idx};
                            req_n      = ~romrd_req;
                        end
                    end
                    if (hit && !crit) begin
                        ack_n = 1'b1;
                        q_n   = buf_data;
                    end
                end
            end
            DRAIN: begin
                if (ack_done || !abort) begin
                    buf_clr = 1'b1;
                    abort_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: toggle-port controller model plus a fixed ROM image,
// directed scenarios followed by randomized reads with stray inval pulses.
module tb_rom_fetch;

    logic        clk = 1'b0;
    logic        init_n;
    logic        cpu_req;
    logic [22:0] cpu_a;
    logic        cpu_ack;
    logic [15:0] cpu_q;
    logic        inval;
    logic        busy;
    logic        romrd_req;
    logic        romrd_ack;
    logic [22:0] romrd_a;
    logic [15:0] romrd_q;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_pulses = 0;
    bit ctl_rand = 1'b0;
    logic [22:0] req_log[$];
    int ack_cyc_q[$];

    rom_fetch dut (
        .clk       (clk),
        .init_n    (init_n),
        .cpu_req   (cpu_req),
        .cpu_a     (cpu_a),
        .cpu_ack   (cpu_ack),
        .cpu_q     (cpu_q),
        .inval     (inval),
        .busy      (busy),
        .romrd_req (romrd_req),
        .romrd_ack (romrd_ack),
        .romrd_a   (romrd_a),
        .romrd_q   (romrd_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (cpu_ack === 1'b1) ack_pulses <= ack_pulses + 1;

    function automatic logic [15:0] rom(input logic [22:0] a);
        case (a)
            23'h80:  rom = 16'h1234;
            23'h81:  rom = 16'h1111;
            23'h82:  rom = 16'h2222;
            23'h83:  rom = 16'h3333;
            default: rom = a[15:0] ^ {a[7:0], 1'b0, a[22:16]} ^ 16'h5A3C;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller: one outstanding request, acks after a latency
    initial begin : ctl
        int cnt;
        bit pend;
        logic [22:0] addr;
        romrd_ack = 1'b0;
        romrd_q = '0;
        pend = 1'b0;
        cnt = 0;
        addr = '0;
        forever begin
            @(posedge clk or negedge init_n);
            if (init_n !== 1'b1) begin
                if (pend) ack_cyc_q.push_back(-1);
                pend = 1'b0;
                romrd_ack = 1'b0;
            end else begin
                #1;
                if (pend) begin
                    chk("romrd_a_stable", 32'(romrd_a), 32'(addr));
                    cnt--;
                    if (cnt <= 0) begin
                        romrd_q = rom(addr);
                        romrd_ack = romrd_req;
                        pend = 1'b0;
                        ack_cyc_q.push_back(cyc);
                    end
                end else if (romrd_req !== romrd_ack) begin
                    pend = 1'b1;
                    addr = romrd_a;
                    req_log.push_back(romrd_a);
                    cnt = ctl_rand ? int'($urandom_range(1, 8)) : 6;
                end
            end
        end
    end

    task automatic cpu_read(input logic [22:0] a, input int inval_at,
                            output logic [15:0] q, output int nc,
                            output int ac);
        @(posedge clk);
        #1;
        cpu_a = a;
        cpu_req = 1'b1;
        q = 16'hxxxx;
        nc = -1;
        ac = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                q = cpu_q;
                nc = i;
                ac = cyc;
                break;
            end
            inval = (i == inval_at);
        end
        inval = 1'b0;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int target);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (req_log.size() >= target) && (busy === 1'b0);
        end
        chk(tag, 32'(done), 1);
    endtask

    task automatic chk_line(input string tag, input int start,
                            input logic [22:0] a);
        logic [22:0] e;
        chk({tag, "_cnt"}, 32'(req_log.size() >= start + 4), 1);
        if (req_log.size() >= start + 4) begin
            for (int k = 0; k < 4; k++) begin
                e = (a & ~23'h3) | ((a + 23'(k)) & 23'h3);
                chk(tag, 32'(req_log[start+k]), 32'(e));
            end
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] q;
        int nc, ac, n0, p0;
        init_n = 1'b0;
        cpu_req = 1'b0;
        cpu_a = '0;
        inval = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_cpu_q", 32'(cpu_q), 0);
        chk("rst_romrd_req", 32'(romrd_req), 0);
        chk("rst_romrd_a", 32'(romrd_a), 0);
        chk("rst_busy", 32'(busy), 0);
        init_n = 1'b1;

        // cold miss
        n0 = req_log.size();
        p0 = ack_pulses;
        cpu_read(23'h80, -1, q, nc, ac);
        chk("cold_q", 32'(q), 32'h1234);
        chk("cold_lat", 32'(ac),
            (ack_cyc_q.size() > n0) ? 32'(ack_cyc_q[n0] + 1) : 32'hdead);
        wait_quiet("cold_done", n0 + 4);
        chk_line("cold_order", n0, 23'h80);
        repeat (3) @(negedge clk);
        chk("cold_busy", 32'(busy), 0);
        chk("cold_no_extra", 32'(req_log.size()), 32'(n0 + 4));
        chk("cold_pulses", 32'(ack_pulses - p0), 1);

        // hit after fill
        n0 = req_log.size();
        cpu_read(23'h81, -1, q, nc, ac);
        chk("hit_q", 32'(q), 32'h1111);
        chk("hit_lat", 32'(nc), 1);
        chk("hit_no_toggle", 32'(req_log.size()), 32'(n0));

        // inval in idle, then critical-word wrap
        @(posedge clk);
        #1 inval = 1'b1;
        @(posedge clk);
        #1 inval = 1'b0;
        n0 = req_log.size();
        p0 = ack_pulses;
        cpu_read(23'h83, -1, q, nc, ac);
        chk("wrap_q", 32'(q), 32'h3333);
        wait_quiet("wrap_done", n0 + 4);
        chk_line("wrap_order", n0, 23'h83);
        chk("wrap_pulses", 32'(ack_pulses - p0), 1);

        // hits during fill
        n0 = req_log.size();
        cpu_read(23'h100, -1, q, nc, ac);
        chk("hf_crit_q", 32'(q), 32'(rom(23'h100)));
        cpu_read(23'h100, -1, q, nc, ac);
        chk("hf_hit_q", 32'(q), 32'(rom(23'h100)));
        chk("hf_hit_lat", 32'(nc), 1);
        chk("hf_still_filling", 32'(req_log.size() < n0 + 4), 1);
        cpu_read(23'h103, -1, q, nc, ac);
        chk("hf_late_q", 32'(q), 32'(rom(23'h103)));
        chk("hf_late_after_ack", 32'((ack_cyc_q.size() > n0 + 3) &&
                                     (ac > ack_cyc_q[n0+3])), 1);
        wait_quiet("hf_done", n0 + 4);
        chk_line("hf_order", n0, 23'h100);

        // miss during fill -> drain -> refetch
        n0 = req_log.size();
        cpu_read(23'h200, -1, q, nc, ac);
        chk("mf_crit_q", 32'(q), 32'(rom(23'h200)));
        cpu_read(23'h400, -1, q, nc, ac);
        chk("mf_new_q", 32'(q), 32'(rom(23'h400)));
        wait_quiet("mf_done", n0 + 6);
        repeat (3) @(negedge clk);
        chk("mf_total", 32'(req_log.size()), 32'(n0 + 6));
        chk("mf_first", 32'(req_log[n0]), 32'h200);
        chk("mf_second", 32'(req_log[n0+1]), 32'h201);
        chk_line("mf_new_order", n0 + 2, 23'h400);

        // inval together with a would-be hit
        n0 = req_log.size();
        cpu_read(23'h401, 0, q, nc, ac);
        chk("ih_q", 32'(q), 32'(rom(23'h401)));
        chk("ih_refetch", 32'(req_log.size() > n0), 1);
        chk("ih_addr", (req_log.size() > n0) ? 32'(req_log[n0]) : 32'hdead,
            32'h401);
        chk("ih_not_fast", 32'(nc > 1), 1);
        wait_quiet("ih_done", n0 + 4);

        // reset mid-fill
        @(posedge clk);
        #1;
        cpu_a = 23'h500;
        cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rm_busy_pre", 32'(busy), 1);
        init_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rm_cpu_ack", 32'(cpu_ack), 0);
        chk("rm_cpu_q", 32'(cpu_q), 0);
        chk("rm_romrd_req", 32'(romrd_req), 0);
        chk("rm_romrd_a", 32'(romrd_a), 0);
        chk("rm_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        n0 = req_log.size();
        cpu_read(23'h500, -1, q, nc, ac);
        chk("rm_q", 32'(q), 32'(rom(23'h500)));
        wait_quiet("rm_done", n0 + 4);
        chk_line("rm_order", n0, 23'h500);

        // randomized reads against the ROM image
        ctl_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [22:0] a;
            int ia;
            a = 23'h600 + 23'($urandom_range(0, 15));
            ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            cpu_read(a, ia, q, nc, ac);
            chk("rand_q", 32'(q), 32'(rom(a)));
            chk("rand_tmo", 32'(nc >= 0), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
